// File: rtl/fxp_pkg.sv
// Shared defaults, FSM state type and op encodings for the fixed-point op arbiter.
// Overflow handling is selected with FXP_SAT_EN (see fxp_alu).
package fxp_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_FRAC_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_alu.sv
// Combinational fixed-point add / multiply with wrap or clamp on overflow.
// Define FXP_SAT_EN to clamp out-of-range results instead of wrapping.
module fxp_alu
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W
) (
    input  logic signed [DATA_W-1:0] din_1,
    input  logic signed [DATA_W-1:0] din_2,
    input  logic                     sel,
    output logic        [DATA_W-1:0] dout
);

    localparam int unsigned WW = 2 * DATA_W;

    logic signed [DATA_W:0]   sum_w;
    logic signed [WW-1:0]     prod_w;

    // Full-precision sum and product; the product is exact in 2*DATA_W bits.
    always_comb begin
        sum_w  = (DATA_W + 1)'(din_1) + (DATA_W + 1)'(din_2);
        prod_w = WW'(din_1) * WW'(din_2);
    end

`ifdef FXP_SAT_EN
    localparam logic signed [WW-1:0] SAT_MAX = WW'({1'b0, {(DATA_W - 1){1'b1}}});
    localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [WW-1:0] res_w;

    always_comb begin
        res_w = (sel == OP_MUL) ? (prod_w >>> FRAC_W) : WW'(sum_w);
        if (res_w > SAT_MAX) begin
            dout = DATA_W'(SAT_MAX);
        end else if (res_w < SAT_MIN) begin
            dout = DATA_W'(SAT_MIN);
        end else begin
            dout = DATA_W'(res_w);
        end
    end
`else
    // Two's-complement wrap: keep only the low DATA_W bits.
    always_comb begin
        dout = (sel == OP_MUL) ? DATA_W'(prod_w >>> FRAC_W) : DATA_W'(sum_w);
    end
`endif

endmodule

// File: rtl/fxp_op_arbiter.sv
// Two-requester round-robin arbiter feeding a shared fixed-point add/multiply unit.
// Overflow mode follows FXP_SAT_EN inside fxp_alu.
module fxp_op_arbiter
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req0_valid,
    input  logic                     i_req1_valid,
    output logic                     o_req0_ready,
    output logic                     o_req1_ready,
    input  logic signed [DATA_W-1:0] i_req0_din_1,
    input  logic signed [DATA_W-1:0] i_req0_din_2,
    input  logic signed [DATA_W-1:0] i_req1_din_1,
    input  logic signed [DATA_W-1:0] i_req1_din_2,
    input  logic                     i_req0_sel,
    input  logic                     i_req1_sel,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_id,
    output logic signed [DATA_W-1:0] o_dout
);

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic               grant_id;
    logic               any_valid;
    logic               accept;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               sel_q;
    logic               id_q;
    logic [DATA_W-1:0]  alu_dout;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        any_valid = i_req0_valid | i_req1_valid;
        grant_id  = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_id = ~last_grant;
        end else if (i_req1_valid) begin
            grant_id = 1'b1;
        end
        accept = (state == IDLE) && any_valid && !i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid)   state_nxt = EXEC;
            EXEC:                     state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Ready is the grant strobe itself, so it is only ever high for one cycle.
    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        if (accept) begin
            o_req0_ready = ~grant_id;
            o_req1_ready = grant_id;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= OP_ADD;
            id_q        <= 1'b0;
            o_dout      <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                id_q       <= grant_id;
                a_q        <= grant_id ? i_req1_din_1 : i_req0_din_1;
                b_q        <= grant_id ? i_req1_din_2 : i_req0_din_2;
                sel_q      <= grant_id ? i_req1_sel   : i_req0_sel;
            end
            if (state == EXEC) begin
                o_dout      <= alu_dout;
                o_rsp_valid <= 1'b1;
                o_rsp_id    <= id_q;
            end else if (state == RESP && i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

    fxp_alu #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_alu (
        .din_1 (a_q),
        .din_2 (b_q),
        .sel   (sel_q),
        .dout  (alu_dout)
    );

endmodule

// File: tb/tb_fxp_op_arbiter.sv
// Self-checking bench for fxp_op_arbiter at default Q16.16 widths.
// Expected results follow FXP_SAT_EN when it is defined for the build.
module tb_fxp_op_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [31:0] i_req0_din_1, i_req0_din_2, i_req1_din_1, i_req1_din_2;
    logic        i_req0_sel, i_req1_sel;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_id;
    logic [31:0] o_dout;

    int vectors;
    int miscompares;

    fxp_op_arbiter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req0_valid (i_req0_valid),
        .i_req1_valid (i_req1_valid),
        .o_req0_ready (o_req0_ready),
        .o_req1_ready (o_req1_ready),
        .i_req0_din_1 (i_req0_din_1),
        .i_req0_din_2 (i_req0_din_2),
        .i_req1_din_1 (i_req1_din_1),
        .i_req1_din_2 (i_req1_din_2),
        .i_req0_sel   (i_req0_sel),
        .i_req1_sel   (i_req1_sel),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_dout       (o_dout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          req;
        logic [31:0] a;
        logic [31:0] b;
        bit          sel;
        logic [31:0] exp;
    } vec_t;

    // Reference: exact integer arithmetic, then clamp or wrap to 32 bits.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input bit sel);
        longint r;
        longint maxv;
        longint minv;
        maxv = 64'sh7FFFFFFF;
        minv = -64'sh80000000;
        if (sel) r = (longint'($signed(a)) * longint'($signed(b))) >>> 16;
        else     r = longint'($signed(a)) + longint'($signed(b));
`ifdef FXP_SAT_EN
        if (r > maxv)      r = maxv;
        else if (r < minv) r = minv;
`else
        if (r > maxv || r < minv) r = r;
`endif
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
    endtask

    // One transaction from a single requester; RESP is held for hold+1 cycles.
    task automatic do_op(input bit req, input logic [31:0] a, input logic [31:0] b,
                         input bit sel, input logic [31:0] exp, input int hold);
        if (req) begin
            i_req1_din_1 = a; i_req1_din_2 = b; i_req1_sel = sel;
            i_req1_valid = 1'b1; i_req0_valid = 1'b0;
        end else begin
            i_req0_din_1 = a; i_req0_din_2 = b; i_req0_sel = sel;
            i_req0_valid = 1'b1; i_req1_valid = 1'b0;
        end
        i_rsp_ready = (hold == 0);
        #1;
        check("grant_ready", {30'd0, o_req1_ready, o_req0_ready}, req ? 32'd2 : 32'd1);
        step();
        drive_idle();
        check("exec_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        step();
        check("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        check("rsp_dout", o_dout, exp);
        check("rsp_id", {31'd0, o_rsp_id}, {31'd0, req});
        for (int k = 0; k < hold; k++) begin
            step();
            check("hold_valid", {31'd0, o_rsp_valid}, 32'd1);
            check("hold_dout", o_dout, exp);
        end
        i_rsp_ready = 1'b1;
        step();
        check("done_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        bit          exp_id;
        int          g;
        int          last_c;
        logic [31:0] held_dout;
        logic [31:0] ra, rb;
        bit          rsel, rreq;

        vectors = 0;
        miscompares = 0;

        tbl[0] = '{req: 1'b0, a: 32'h00018000, b: 32'h00024000, sel: 1'b0, exp: 32'h0003C000};
        tbl[1] = '{req: 1'b1, a: 32'h00018000, b: 32'h00020000, sel: 1'b1, exp: 32'h00030000};
        tbl[2] = '{req: 1'b1, a: 32'hFFFF0000, b: 32'h00008000, sel: 1'b1, exp: 32'hFFFF8000};
        tbl[3] = '{req: 1'b0, a: 32'hFFFF8000, b: 32'hFFFF8000, sel: 1'b0, exp: 32'hFFFF0000};
        tbl[4] = '{req: 1'b0, a: 32'hFFFF0000, b: 32'hFFFF0000, sel: 1'b1, exp: 32'h00010000};
`ifdef FXP_SAT_EN
        tbl[5] = '{req: 1'b0, a: 32'h7FFF0000, b: 32'h00010000, sel: 1'b0, exp: 32'h7FFFFFFF};
        tbl[6] = '{req: 1'b1, a: 32'h7FFF0000, b: 32'h7FFF0000, sel: 1'b1, exp: 32'h7FFFFFFF};
`else
        tbl[5] = '{req: 1'b0, a: 32'h7FFF0000, b: 32'h00010000, sel: 1'b0, exp: 32'h80000000};
        tbl[6] = '{req: 1'b1, a: 32'h7FFF0000, b: 32'h7FFF0000, sel: 1'b1, exp: 32'h00010000};
`endif

        // Reset with both requesters active: nothing may be granted.
        i_rst = 1'b1;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        i_req0_din_1 = '0; i_req0_din_2 = '0; i_req1_din_1 = '0; i_req1_din_2 = '0;
        i_req0_sel = 1'b0; i_req1_sel = 1'b0;
        i_rsp_ready = 1'b1;
        step();
        step();
        check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("rst_dout", o_dout, 32'd0);
        check("rst_rsp_id", {31'd0, o_rsp_id}, 32'd0);
        check("rst_ready", {30'd0, o_req1_ready, o_req0_ready}, 32'd0);

        // Continuous tie: grants alternate 0,1,0,1 at a fixed 3-cycle pace.
        i_req0_din_1 = 32'h00010000; i_req0_din_2 = 32'h00010000;
        i_req1_din_1 = 32'h00030000; i_req1_din_2 = 32'h00010000;
        i_rst = 1'b0;
        exp_id = 1'b0;
        g = 0;
        last_c = 0;
        for (int c = 0; c < 20 && g < 4; c++) begin
            #1;
            if (o_req0_ready || o_req1_ready) begin
                check("rr_single", {31'd0, o_req0_ready & o_req1_ready}, 32'd0);
                check("rr_id", {31'd0, o_req1_ready}, {31'd0, exp_id});
                if (g > 0) check("rr_gap", 32'(c - last_c), 32'd3);
                exp_id = ~exp_id;
                last_c = c;
                g++;
            end
            step();
        end
        check("rr_count", 32'(g), 32'd4);
        drive_idle();
        step();
        step();
        step();

        foreach (tbl[i]) begin
            do_op(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].exp, 0);
        end

        // Backpressure: response frozen, late requests neither granted nor retained.
        i_req0_din_1 = 32'h00050000; i_req0_din_2 = 32'h00020000; i_req0_sel = 1'b1;
        i_req0_valid = 1'b1;
        i_rsp_ready = 1'b0;
        step();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b1;
        step();
        held_dout = o_dout;
        check("bp_dout", held_dout, 32'h000A0000);
        for (int k = 0; k < 5; k++) begin
            i_req0_valid = 1'b1;
            #1;
            check("bp_ready", {30'd0, o_req1_ready, o_req0_ready}, 32'd0);
            check("bp_valid", {31'd0, o_rsp_valid}, 32'd1);
            check("bp_stable", o_dout, held_dout);
            check("bp_id", {31'd0, o_rsp_id}, 32'd0);
            step();
        end
        drive_idle();
        i_rsp_ready = 1'b1;
        step();
        check("bp_done", {31'd0, o_rsp_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("drop_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        end

        // Reset mid-operation aborts it; the tie then goes to requester 0 again.
        do_op(1'b0, 32'h00010000, 32'h00010000, 1'b0, 32'h00020000, 0);
        i_req1_din_1 = 32'h00070000; i_req1_din_2 = 32'h00010000; i_req1_sel = 1'b0;
        i_req1_valid = 1'b1;
        step();
        i_req1_valid = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("abort_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("abort_dout", o_dout, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        end
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        #1;
        check("abort_tie", {30'd0, o_req1_ready, o_req0_ready}, 32'd1);
        step();
        drive_idle();
        step();
        step();
        step();

        // Randomised single-requester traffic against the arithmetic model.
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            rb = $urandom;
            rsel = 1'($urandom_range(0, 1));
            rreq = 1'($urandom_range(0, 1));
            if (n % 3 == 0) begin
                ra = 32'($signed(ra) >>> 12);
                rb = 32'($signed(rb) >>> 12);
            end
            do_op(rreq, ra, rb, rsel, model(ra, rb, rsel), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fxp_op_arbiter.md
FXP_OP_ARBITER -- requirements
Module: fxp_op_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter FRAC_W, default 16, fractional bits (Q16.16 at defaults).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all logic samples on the rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-005 The block SHALL have ports i_req0_valid / i_req1_valid, input, 1 each, requester operation valid.
REQ-006 The block SHALL have ports o_req0_ready / o_req1_ready, output, 1 each, request accepted this cycle.
REQ-007 The block SHALL have ports i_req0_din_1, i_req0_din_2, i_req1_din_1, i_req1_din_2, input, DATA_W each, signed operands.
REQ-008 The block SHALL have ports i_req0_sel / i_req1_sel, input, 1 each: 0 = add, 1 = multiply.
REQ-009 The block SHALL have port o_rsp_valid, output, 1, result valid.
REQ-010 The block SHALL have port i_rsp_ready, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port o_rsp_id, output, 1, index of the requester owning the result.
REQ-012 The block SHALL have port o_dout, output, DATA_W, signed result.

Function
REQ-013 The block SHALL be an FSM with states IDLE, EXEC, RESP.
REQ-014 IDLE: if any valid, grant one requester, assert its ready for exactly that cycle, latch its operands, sel and id, go to EXEC; else stay in IDLE.
REQ-015 Only one ready SHALL be high per cycle; ready SHALL be low in EXEC and RESP.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the last-grant pointer updates only on a grant.
REQ-017 EXEC: compute the latched operation, register it into o_dout, go to RESP (one cycle).
REQ-018 RESP: hold o_rsp_valid=1 with o_dout and o_rsp_id stable until i_rsp_ready=1, then return to IDLE; a new grant is possible at the earliest in the next cycle (grant-to-response latency 2 cycles, minimum throughput one op per 3 cycles).
REQ-019 Add: compute a DATA_W+1-bit signed sum of din_1 and din_2.
REQ-020 Multiply: compute a 2*DATA_W-bit signed product, then arithmetic right shift by FRAC_W (truncation toward negative infinity).
REQ-021 Without saturation (REQ-026), the result SHALL be the low DATA_W bits (two's-complement wrap).
REQ-022 A valid deasserted before being granted SHALL be dropped without effect; requests arriving in EXEC/RESP wait.

Reset
REQ-023 With i_rst high at a clock edge: state=IDLE, o_rsp_valid=0, o_dout=0, o_rsp_id=0, both readies 0, last-grant pointer=1 (requester 0 wins first tie).
REQ-024 Reset in EXEC or RESP SHALL abort the operation; no response is issued for it.

Configuration
REQ-025 Macro FXP_SAT_EN SHALL select overflow handling.
REQ-026 With FXP_SAT_EN defined: results above the DATA_W signed maximum clamp to 0x7FFFFFFF, below the minimum clamp to 0x80000000 (defaults); without it: wrap per REQ-021.

Structure
REQ-027 Package fxp_pkg SHALL hold DATA_W/FRAC_W defaults, the FSM state typedef and the op encoding constants (OP_ADD=0, OP_MUL=1).
REQ-028 Arithmetic SHALL live in one combinational sub-module fxp_alu (din_1, din_2, sel -> dout, honouring FXP_SAT_EN); the arbiter instantiates it once.

Verification
REQ-029 Req0 add 0x00018000+0x00024000, i_rsp_ready=1 -> o_rsp_valid 2 cycles after grant, o_dout=0x0003C000, o_rsp_id=0.
REQ-030 Req1 mul 0x00018000*0x00020000 -> o_dout=0x00030000, id=1; mul 0xFFFF0000*0x00008000 -> 0xFFFF8000.
REQ-031 Both valid continuously after reset -> grants alternate 0,1,0,1; each ready pulses exactly one cycle.
REQ-032 i_rsp_ready held low 5 cycles in RESP -> o_rsp_valid, o_dout, o_rsp_id stable, no ready asserted, completes on first ready.
REQ-033 Add 0x7FFF0000+0x00010000 -> 0x80000000 without FXP_SAT_EN, 0x7FFFFFFF with it; mul 0x7FFF0000*0x7FFF0000 -> 0x7FFFFFFF with it.
REQ-034 i_rst pulsed during EXEC -> next cycle IDLE, o_rsp_valid=0, o_dout=0, no response; next tie grants requester 0.
